// File: rtl/noc_pkg.sv
// noc_pkg: shared flit-field constants and egress FSM state type
package noc_pkg;
  localparam int DWIDTH = 16;
  localparam int ADDR_W = 6;
  localparam int DEST_MSB = DWIDTH - 1;
  localparam int DEST_LSB = DWIDTH - ADDR_W;
  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;
endpackage

// File: rtl/spine_egress_buffer_if.sv
// spine_egress_buffer_if: spine-side input, link handshake and status bundle
interface spine_egress_buffer_if #(
  parameter int DWIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  import noc_pkg::*;
  logic [DWIDTH-1:0] in_data, out_data;
  logic in_valid, out_valid, out_ready, fifo_full, fifo_empty, overflow, stall_err, clear_err;
  logic [ADDR_W-1:0] out_dest_addr;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0] drop_cnt;
  modport master (
    output in_data, in_valid, out_ready, clear_err,
    input out_data, out_valid, out_dest_addr, fifo_level, fifo_full, fifo_empty, drop_cnt, overflow, stall_err
  );
  modport slave (
    input in_data, in_valid, out_ready, clear_err,
    output out_data, out_valid, out_dest_addr, fifo_level, fifo_full, fifo_empty, drop_cnt, overflow, stall_err
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with show-ahead head; caller must not push when full without a pop
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  // storage needs no reset; occupancy tracking makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
  assign o_data = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full = r_level == (AW+1)'(DEPTH);
  assign o_empty = r_level == '0;
endmodule

// File: rtl/spine_egress_buffer.sv
// spine_egress_buffer: absorbs a no-backpressure spine output and drives a valid/ready link
module spine_egress_buffer #(
  parameter int DWIDTH = noc_pkg::DWIDTH,
  parameter int DEPTH = 8,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  spine_egress_buffer_if.slave bus
);
  import noc_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [DWIDTH-1:0] w_head, r_data;
  logic [AW:0] w_level;
  logic w_full, w_empty, w_pop, w_push, w_drop, w_hs, w_stall;
  logic r_valid, r_ovf, r_stall_err;
  logic [SW-1:0] r_cnt;
  logic [CNT_W-1:0] r_drop;
  state_t r_state, w_next;
  assign w_hs = r_valid && bus.out_ready;
  assign w_stall = r_valid && !bus.out_ready;
  assign w_pop = !w_empty && (!r_valid || bus.out_ready);
  assign w_push = bus.in_valid && (!w_full || w_pop);
  assign w_drop = bus.in_valid && !w_push;
  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk,
    .rst(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(bus.in_data),
    .o_data(w_head),
    .o_level(w_level),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  // output register: reload from the FIFO head whenever it is free or being taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data <= w_head;
    end else if (bus.out_ready) r_valid <= 1'b0;
  end
  // link state: idle until a load, stall after STALL_LIMIT unaccepted cycles
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE || w_hs) ? (w_pop ? SEND : IDLE)
           : (r_state == SEND && w_stall && r_cnt >= SW'(STALL_LIMIT - 1)) ? STALL : r_state;
  end
  // state register, saturating stall counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_drop <= '0;
      r_ovf <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= !w_stall ? '0 : (r_cnt == SW'(STALL_LIMIT)) ? r_cnt : r_cnt + 1'b1;
      r_drop <= bus.clear_err ? CNT_W'(w_drop) : (w_drop && r_drop != '1) ? r_drop + 1'b1 : r_drop;
      r_ovf <= w_drop || (r_ovf && !bus.clear_err);
      r_stall_err <= bus.clear_err ? 1'b0 : (w_next == STALL) || r_stall_err;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
  assign bus.out_dest_addr = r_data[DWIDTH-1 -: ADDR_W];
  assign bus.fifo_level = w_level;
  assign bus.fifo_full = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.drop_cnt = r_drop;
  assign bus.overflow = r_ovf;
  assign bus.stall_err = r_stall_err;
endmodule

// File: tb/tb_spine_egress_buffer.sv
// tb_spine_egress_buffer: directed and random stimulus against a queue-based reference model
module tb_spine_egress_buffer;
  localparam int DEPTH = 8;
  localparam int LIMIT = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] fq[$];
  logic ov = 1'b0;
  logic [15:0] od = '0;
  int sc = 0;
  int dc = 0;
  logic of = 1'b0;
  logic se = 1'b0;
  logic [15:0] held;
  spine_egress_buffer_if #(.DWIDTH(16), .DEPTH(DEPTH), .CNT_W(16)) bus ();
  spine_egress_buffer #(.DWIDTH(16), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic v, input logic [15:0] d, input logic rdy, input logic clr, input logic rs);
    logic pop, push, drop;
    int sn;
    if (rs) begin
      fq.delete();
      ov = 0; od = 0; sc = 0; dc = 0; of = 0; se = 0;
    end else begin
      pop = fq.size() > 0 && (!ov || rdy);
      push = v && (fq.size() < DEPTH || pop);
      drop = v && !push;
      sn = (ov && !rdy) ? ((sc == LIMIT) ? LIMIT : sc + 1) : 0;
      se = clr ? 1'b0 : ((sn == LIMIT) ? 1'b1 : se);
      sc = sn;
      if (pop) begin
        od = fq.pop_front();
        ov = 1;
      end else if (rdy) ov = 0;
      if (push) fq.push_back(d);
      dc = clr ? int'(drop) : ((drop && dc != 65535) ? dc + 1 : dc);
      of = drop || (of && !clr);
    end
  endtask
  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk("out_data", 32'(bus.out_data), 32'(od));
      chk("dest_addr", 32'(bus.out_dest_addr), 32'(od[15:10]));
    end
    chk("fifo_level", 32'(bus.fifo_level), 32'(fq.size()));
    chk("fifo_full", 32'(bus.fifo_full), 32'(fq.size() == DEPTH));
    chk("fifo_empty", 32'(bus.fifo_empty), 32'(fq.size() == 0));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(dc));
    chk("overflow", 32'(bus.overflow), 32'(of));
    chk("stall_err", 32'(bus.stall_err), 32'(se));
    chk("state", 32'(dut.r_state), !ov ? 32'd0 : (sc == LIMIT) ? 32'd2 : 32'd1);
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic rdy, input logic clr, input logic rs);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = rdy;
    bus.clear_err = clr;
    reset = rs;
    @(posedge clk);
    model(v, d, rdy, clr, rs);
    #1;
    check_all();
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'($urandom()), 1'b0, 1'b0, 1'b0);
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.clear_err = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("rst_dest", 32'(bus.out_dest_addr), 32'h0);
    step(1, 16'hA813, 1, 0, 0);
    chk("lat_edge1", 32'(bus.out_valid), 32'h0);
    step(0, 0, 1, 0, 0);
    chk("lat_edge2", 32'(bus.out_valid), 32'h1);
    chk("dest_a813", 32'(bus.out_dest_addr), 32'h2A);
    step(0, 0, 1, 0, 0);
    chk("single_idle", 32'(bus.out_valid), 32'h0);
    fill(20);
    chk("burst_drops", 32'(bus.drop_cnt), 32'd11);
    chk("burst_ovf", 32'(bus.overflow), 32'h1);
    chk("burst_full", 32'(bus.fifo_full), 32'h1);
    drain(11);
    chk("burst_drained", 32'(bus.out_valid), 32'h0);
    step(0, 0, 0, 1, 0);
    chk("clr_ovf", 32'(bus.overflow), 32'h0);
    fill(9);
    for (int i = 0; i < 13; i++) begin
      step(1, 16'($urandom()), 1, 0, 0);
      chk("stream_level", 32'(bus.fifo_level), 32'd8);
      chk("stream_nodrop", 32'(bus.drop_cnt), 32'd0);
    end
    drain(11);
    step(1, 16'h5C3E, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    held = bus.out_data;
    chk("stall_held_val", 32'(held), 32'h5C3E);
    for (int i = 1; i <= 70; i++) begin
      step(0, 0, 0, 0, 0);
      chk("stall_hold", 32'(bus.out_data), 32'h5C3E);
      if (i == 63) chk("stall_63", 32'(bus.stall_err), 32'h0);
      if (i == 64) chk("stall_64", 32'(bus.stall_err), 32'h1);
    end
    step(0, 0, 0, 1, 0);
    chk("stall_clr", 32'(bus.stall_err), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("stall_reset", 32'(bus.stall_err), 32'h1);
    drain(3);
    chk("stall_sticky", 32'(bus.stall_err), 32'h1);
    step(0, 0, 0, 1, 0);
    chk("stall_cleared", 32'(bus.stall_err), 32'h0);
    fill(11);
    chk("pre_clr_drops", 32'(bus.drop_cnt), 32'd2);
    step(1, 16'hBEEF, 0, 1, 0);
    chk("clr_drop_cnt", 32'(bus.drop_cnt), 32'd1);
    chk("clr_drop_ovf", 32'(bus.overflow), 32'h1);
    drain(11);
    step(0, 0, 0, 1, 0);
    fill(5);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_level", 32'(bus.fifo_level), 32'h0);
    chk("mid_rst_drops", 32'(bus.drop_cnt), 32'h0);
    drain(6);
    chk("no_stale", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, 16'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, 1'b0);
    drain(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
